axi4_lite_arbiter_2to1: RTL
===========================

// Module: axi4_lite_arbiter_2to1
// PURPOSE
//  Shares one AXI4-Lite slave (e.g. a register bank or the error slave) between two masters.
//  Write and read channels are arbitrated independently, each round-robin between the two masters.
//  Only one transaction per channel is in flight; a grant is held until that transaction's response completes.
//  Sits between two CPU/DMA-side axi4_if masters and one downstream axi4_if slave.
// PARAMETERS
//  A  32  address width of all three axi4_if ports
//  N  4   data width in bytes (data bus = 8*N bits)
//  I  1   ID width; IDs pass through unchanged
// PORTS
//  aclk     input   1      clock; all logic on posedge
//  areset   input   1      synchronous, active-high reset
//  axi4_s0  axi4_if  -     slave port to master 0 (priority on first tie after reset)
//  axi4_s1  axi4_if  -     slave port to master 1
//  axi4_m   axi4_if  -     master port to the shared slave
// BEHAVIOUR
//  Reset: both FSMs go to IDLE; rr pointer = 0 (master 0 favoured). Forced low while in reset/IDLE:
//   axi4_m.awvalid/wvalid/bready/arvalid/rready, and on both slave ports
//   awready/wready/bvalid/arready/rvalid.
//  Write request k = axi4_sk.awvalid & axi4_sk.wvalid. Read request k = axi4_sk.arvalid.
//  Write FSM states: IDLE -> ADDR -> RESP -> IDLE.
//   IDLE: if any request, register grant g (single request wins; both -> the rr pointer's master),
//     go to ADDR next cycle. Grant-to-awvalid latency = 1 cycle. IDLE never asserts ready.
//   ADDR: axi4_m.aw*/w* driven from master g. awvalid held until aw handshake, wvalid until
//     w handshake, tracked by flags aw_done/w_done (cleared on entry to ADDR).
//     axi4_sg.awready/wready = axi4_m.awready/wready gated by !aw_done/!w_done. AW and W may
//     complete in either order or the same cycle. Go to RESP once both are done.
//   RESP: axi4_m.bready = axi4_sg.bready; axi4_sg.bvalid/bresp/bid = axi4_m.*.
//     On bvalid & bready: rr pointer <= ~g, go to IDLE.
//  Read FSM states: IDLE -> ADDR -> DATA -> IDLE; same grant/rr rules, separate pointer.
//   ADDR: forward ar* from g until ar handshake. DATA: forward r* (rdata,rresp,rid,rlast)
//     to g. On rvalid & rready: pointer <= ~g, go to IDLE.
//  Non-granted master: ready and valid outputs held 0. Its request stays pending, not dropped.
//  Masters must hold awvalid/wvalid stable (AXI rule). Payload is combinational pass-through:
//   no added latency beyond the grant cycle.
//  Fairness: with both requesting continuously, grants alternate 0,1,0,1 per channel.
//  The write and read channels never block each other; both may be active in the same cycle.
//  Reset mid-transaction: FSMs return to IDLE next edge, the transaction is abandoned and no
//   response is forwarded. The downstream slave is reset with the same areset.
//  Unexpected downstream bvalid/rvalid outside RESP/DATA: ignored (bready/rready held 0).
// STRUCTURE
//  Package axi4_lite_arb_pkg:
//   - typedef enum {IDLE, ADDR, RESP} arb_state_t, used by both FSMs (RESP means DATA for reads)
//   - typedef logic arb_sel_t
//  Sub-module axi4_lite_rr_arb2, instantiated twice (write and read):
//   - inputs req[1:0], start, done
//   - outputs grant (arb_sel_t), busy
//   - grant is locked from start to done; the pointer advances on done
//  The top level contains the channel muxes and the aw_done/w_done flags.
// TESTING
//  1 Master 0 alone writes 0x10/0xA5A5A5A5; slave gives awready, wready and bvalid a cycle later:
//    transaction completes, s0 gets bresp=OKAY, s1 sees no ready or valid.
//  2 Both masters request a write in the same cycle, right after reset:
//    order is m0 then m1; with a further m0 request queued, the next grant is m0 again
//    (pattern 0,1,0).
//  3 Slave accepts W three cycles before AW: wvalid drops after the w handshake, awvalid
//    stays high, FSM enters RESP only after the aw handshake, and exactly one B is forwarded.
//  4 Simultaneous m1 read and m0 write: both proceed in parallel; rdata 0xeeeec0de with
//    rresp=2'b10 reaches s1 only.
//  5 Slave holds bvalid and s0 holds bready=0 for 5 cycles: grant and bvalid are stable, and
//    m1's pending write stays unserved until the B handshake.
//  6 areset asserted while in ADDR: all valid/ready outputs are 0 on the next cycle, the rr
//    pointer is 0, and a fresh m1 request completes normally.

Source files
------------

// File: rtl/axi4_lite_arb_pkg.sv
// Package for the 2:1 AXI4-Lite arbiter.
// Holds the per-channel FSM state type, the master-select type and the
// two-requester round-robin pick function.
package axi4_lite_arb_pkg;

  // Shared by write and read FSMs; for the read channel RESP is the data phase.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // 0 selects master 0, 1 selects master 1.
  typedef logic arb_sel_t;

  // A lone requester always wins; on a tie the round-robin pointer decides.
  function automatic arb_sel_t rr_pick(input logic [1:0] req, input arb_sel_t ptr);
    case (req)
      2'b01:   rr_pick = 1'b0;
      2'b10:   rr_pick = 1'b1;
      default: rr_pick = ptr;
    endcase
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4-Lite bundle (with IDs and rlast) shared by the two upstream masters
// and the downstream slave.
// Parameters: A address width, N data width in bytes, I ID width.
// Modports: master (drives requests), slave (drives responses).
interface axi4_if #(
  parameter int A = 32,
  parameter int N = 4,
  parameter int I = 1
) ();
  logic [I-1:0]   awid;
  logic [A-1:0]   awaddr;
  logic           awvalid;
  logic           awready;
  logic [8*N-1:0] wdata;
  logic [N-1:0]   wstrb;
  logic           wvalid;
  logic           wready;
  logic [I-1:0]   bid;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready;
  logic [I-1:0]   arid;
  logic [A-1:0]   araddr;
  logic           arvalid;
  logic           arready;
  logic [I-1:0]   rid;
  logic [8*N-1:0] rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;

  modport master (
    output awid, awaddr, awvalid, wdata, wstrb, wvalid, bready,
           arid, araddr, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready,
           rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awvalid, wdata, wstrb, wvalid, bready,
           arid, araddr, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready,
           rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_lite_rr_arb2.sv
// Two-requester round-robin grant holder for one AXI channel.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset (pointer back to master 0)
//   req_i   request per master
//   start_i latch a new grant (ignored while busy or with no request)
//   done_i  transaction finished: release grant, advance pointer
//   grant_o locked grant, stable from start to done
//   busy_o  a grant is currently held
module axi4_lite_rr_arb2
  import axi4_lite_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       start_i,
  input  logic       done_i,
  output arb_sel_t   grant_o,
  output logic       busy_o
);

  arb_sel_t ptr_q, ptr_d;
  arb_sel_t grant_q, grant_d;
  logic     busy_q, busy_d;

  always_comb begin
    ptr_d   = ptr_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    if (busy_q) begin
      if (done_i) begin
        busy_d = 1'b0;
        // Favour the other master next time so a continuous pair alternates.
        ptr_d  = ~grant_q;
      end
    end else if (start_i && (req_i != 2'b00)) begin
      busy_d  = 1'b1;
      grant_d = rr_pick(req_i, ptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/axi4_lite_arbiter_2to1.sv
// Shares one AXI4-Lite slave between two masters. Write and read channels
// are arbitrated independently (round-robin each), one transaction in flight
// per channel, grant held until that transaction's response completes.
// Payload paths are combinational; only the grant costs one cycle.
// Ports:
//   aclk     clock
//   areset   synchronous active-high reset
//   axi4_s0  slave port facing master 0 (wins the first tie after reset)
//   axi4_s1  slave port facing master 1
//   axi4_m   master port to the shared slave
module axi4_lite_arbiter_2to1
  import axi4_lite_arb_pkg::*;
#(
  parameter int A = 32,
  parameter int N = 4,
  parameter int I = 1
) (
  input  logic  aclk,
  input  logic  areset,
  axi4_if.slave  axi4_s0,
  axi4_if.slave  axi4_s1,
  axi4_if.master axi4_m
);

  arb_state_t wr_st_q, wr_st_d, rd_st_q, rd_st_d;
  logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [1:0] wr_req, rd_req;
  arb_sel_t   wr_g, rd_g;
  logic       wr_busy, rd_busy, wr_start, rd_start, wr_done, rd_done;
  logic       wr_addr, wr_resp, rd_addr, rd_data;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic       sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic [A-1:0]   sel_awaddr, sel_araddr;
  logic [I-1:0]   sel_awid, sel_arid;
  logic [8*N-1:0] sel_wdata;
  logic [N-1:0]   sel_wstrb;

  // A write request needs both AW and W offered by the master.
  assign wr_req   = {axi4_s1.awvalid & axi4_s1.wvalid, axi4_s0.awvalid & axi4_s0.wvalid};
  assign rd_req   = {axi4_s1.arvalid, axi4_s0.arvalid};
  assign wr_addr  = (wr_st_q == ADDR);
  assign wr_resp  = (wr_st_q == RESP);
  assign rd_addr  = (rd_st_q == ADDR);
  assign rd_data  = (rd_st_q == RESP);
  assign wr_start = (wr_st_q == IDLE) & ~wr_busy & (wr_req != 2'b00);
  assign rd_start = (rd_st_q == IDLE) & ~rd_busy & (rd_req != 2'b00);

  axi4_lite_rr_arb2 u_wr_arb (
    .clk_i  (aclk),
    .rst_i  (areset),
    .req_i  (wr_req),
    .start_i(wr_start),
    .done_i (wr_done),
    .grant_o(wr_g),
    .busy_o (wr_busy)
  );

  axi4_lite_rr_arb2 u_rd_arb (
    .clk_i  (aclk),
    .rst_i  (areset),
    .req_i  (rd_req),
    .start_i(rd_start),
    .done_i (rd_done),
    .grant_o(rd_g),
    .busy_o (rd_busy)
  );

  // Request side of the granted master.
  assign sel_awvalid = wr_g ? axi4_s1.awvalid : axi4_s0.awvalid;
  assign sel_wvalid  = wr_g ? axi4_s1.wvalid  : axi4_s0.wvalid;
  assign sel_bready  = wr_g ? axi4_s1.bready  : axi4_s0.bready;
  assign sel_awaddr  = wr_g ? axi4_s1.awaddr  : axi4_s0.awaddr;
  assign sel_awid    = wr_g ? axi4_s1.awid    : axi4_s0.awid;
  assign sel_wdata   = wr_g ? axi4_s1.wdata   : axi4_s0.wdata;
  assign sel_wstrb   = wr_g ? axi4_s1.wstrb   : axi4_s0.wstrb;
  assign sel_arvalid = rd_g ? axi4_s1.arvalid : axi4_s0.arvalid;
  assign sel_rready  = rd_g ? axi4_s1.rready  : axi4_s0.rready;
  assign sel_araddr  = rd_g ? axi4_s1.araddr  : axi4_s0.araddr;
  assign sel_arid    = rd_g ? axi4_s1.arid    : axi4_s0.arid;

  // Downstream: valids only in their phase, each dropped once its beat is taken.
  assign axi4_m.awvalid = wr_addr & sel_awvalid & ~aw_done_q;
  assign axi4_m.wvalid  = wr_addr & sel_wvalid & ~w_done_q;
  assign axi4_m.bready  = wr_resp & sel_bready;
  assign axi4_m.awaddr  = sel_awaddr;
  assign axi4_m.awid    = sel_awid;
  assign axi4_m.wdata   = sel_wdata;
  assign axi4_m.wstrb   = sel_wstrb;
  assign axi4_m.arvalid = rd_addr & sel_arvalid;
  assign axi4_m.rready  = rd_data & sel_rready;
  assign axi4_m.araddr  = sel_araddr;
  assign axi4_m.arid    = sel_arid;

  assign aw_hs   = axi4_m.awvalid & axi4_m.awready;
  assign w_hs    = axi4_m.wvalid & axi4_m.wready;
  assign b_hs    = axi4_m.bvalid & axi4_m.bready;
  assign ar_hs   = axi4_m.arvalid & axi4_m.arready;
  assign r_hs    = axi4_m.rvalid & axi4_m.rready;
  assign wr_done = wr_resp & b_hs;
  assign rd_done = rd_data & r_hs;

  // Upstream: only the granted master sees ready/valid; payload fans out to both.
  assign axi4_s0.awready = wr_addr & ~wr_g & axi4_m.awready & ~aw_done_q;
  assign axi4_s1.awready = wr_addr &  wr_g & axi4_m.awready & ~aw_done_q;
  assign axi4_s0.wready  = wr_addr & ~wr_g & axi4_m.wready & ~w_done_q;
  assign axi4_s1.wready  = wr_addr &  wr_g & axi4_m.wready & ~w_done_q;
  assign axi4_s0.bvalid  = wr_resp & ~wr_g & axi4_m.bvalid;
  assign axi4_s1.bvalid  = wr_resp &  wr_g & axi4_m.bvalid;
  assign axi4_s0.bresp   = axi4_m.bresp;
  assign axi4_s1.bresp   = axi4_m.bresp;
  assign axi4_s0.bid     = axi4_m.bid;
  assign axi4_s1.bid     = axi4_m.bid;
  assign axi4_s0.arready = rd_addr & ~rd_g & axi4_m.arready;
  assign axi4_s1.arready = rd_addr &  rd_g & axi4_m.arready;
  assign axi4_s0.rvalid  = rd_data & ~rd_g & axi4_m.rvalid;
  assign axi4_s1.rvalid  = rd_data &  rd_g & axi4_m.rvalid;
  assign axi4_s0.rdata   = axi4_m.rdata;
  assign axi4_s1.rdata   = axi4_m.rdata;
  assign axi4_s0.rresp   = axi4_m.rresp;
  assign axi4_s1.rresp   = axi4_m.rresp;
  assign axi4_s0.rid     = axi4_m.rid;
  assign axi4_s1.rid     = axi4_m.rid;
  assign axi4_s0.rlast   = axi4_m.rlast;
  assign axi4_s1.rlast   = axi4_m.rlast;

  // Write FSM: AW and W may finish in either order; RESP only once both are in.
  always_comb begin
    wr_st_d   = wr_st_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (wr_st_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (wr_start) wr_st_d = ADDR;
      end
      ADDR: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) wr_st_d = RESP;
      end
      RESP: begin
        if (b_hs) wr_st_d = IDLE;
      end
      default: wr_st_d = IDLE;
    endcase
  end

  // Read FSM: RESP here is the data phase.
  always_comb begin
    rd_st_d = rd_st_q;
    case (rd_st_q)
      IDLE:    if (rd_start) rd_st_d = ADDR;
      ADDR:    if (ar_hs) rd_st_d = RESP;
      RESP:    if (r_hs) rd_st_d = IDLE;
      default: rd_st_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_st_q   <= IDLE;
      rd_st_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      wr_st_q   <= wr_st_d;
      rd_st_q   <= rd_st_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule
